// File: rtl/stage_mem_if.sv
// Shared types for the memory stage and the hazard-unit request interface.
package stage_mem_pkg;

  typedef enum logic [1:0] {
    RESULT_ALU = 2'd0,
    RESULT_MEM = 2'd1,
    RESULT_PC4 = 2'd2
  } resultsrc_t;

  typedef struct packed {
    logic       regwrite;
    logic       memwrite;
    resultsrc_t resultsrc;
  } control_signal_t;

  typedef struct packed {
    logic        valid;
    logic [3:0]  cause;
    logic [31:0] pc;
    logic [31:0] tval;
  } trap_req_t;

  typedef struct packed {
    logic [4:0] rd_m;
    logic       regwrite_m;
    logic       load_m;
    logic       stall_m;
  } hazard_req_t;

endpackage

interface hazard_interface;
  import stage_mem_pkg::*;

  hazard_req_t req;

  modport requester (output req);
  modport responder (input req);
endinterface

// File: rtl/stage_mem.sv
// Memory-access pipeline stage: EX/M register, data-memory request/grant
// handshake, misalignment traps and load-data formatting for writeback.
module stage_mem
  import stage_mem_pkg::*;
#(
  parameter bit         MISALIGN_TRAP     = 1'b1,
  parameter logic [3:0] CAUSE_LD_MISALIGN = 4'd4,
  parameter logic [3:0] CAUSE_ST_MISALIGN = 4'd6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  control_signal_t           control_signal_e,
  input  logic [2:0]                funct3_e,
  input  logic [4:0]                rd_e,
  input  logic [31:0]               alu_result_e,
  input  logic [31:0]               store_data_e,
  input  logic [31:0]               pc_e,
  input  trap_req_t                 trap_req_e,
  input  logic                      kill_w,
  output control_signal_t           control_signal_m,
  output logic [4:0]                rd_m,
  output logic [31:0]               result_m,
  output logic [31:0]               memresult_m,
  output trap_req_t                 trap_req_m,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [31:0]               dmem_addr,
  output logic [3:0]                dmem_be,
  output logic [31:0]               dmem_wdata,
  input  logic                      dmem_gnt,
  input  logic                      dmem_rvalid,
  input  logic [31:0]               dmem_rdata,
  output logic                      stall_m,
  hazard_interface.requester        hazard_bus
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t state_q, state_d;

  control_signal_t ctrl_q;
  logic [2:0]      f3_q;
  logic [4:0]      rd_q;
  logic [31:0]     alu_q;
  logic [31:0]     sd_q;
  logic [31:0]     pc_q;
  trap_req_t       trap_q;

  logic            lf_valid_q;
  logic [2:0]      lf_f3_q;
  logic [1:0]      lf_off_q;

  logic        is_load, mem_op, is_half, is_word;
  logic        misaligned, mis_trap, trap_in;
  logic [1:0]  off;
  logic        req, stall, rd_gnt;
  logic [3:0]  be_raw;
  logic [31:0] wdata_raw;
  hazard_req_t haz;

  // A kill outranks a stall so a trapping WB can always flush a waiting access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= '0;
      f3_q   <= '0;
      rd_q   <= '0;
      alu_q  <= '0;
      sd_q   <= '0;
      pc_q   <= '0;
      trap_q <= '0;
    end else if (kill_w) begin
      ctrl_q <= '0;
      f3_q   <= '0;
      rd_q   <= '0;
      alu_q  <= '0;
      sd_q   <= '0;
      pc_q   <= '0;
      trap_q <= '0;
    end else if (!stall) begin
      ctrl_q <= control_signal_e;
      f3_q   <= funct3_e;
      rd_q   <= rd_e;
      alu_q  <= alu_result_e;
      sd_q   <= store_data_e;
      pc_q   <= pc_e;
      trap_q <= trap_req_e;
    end
  end

  assign is_load    = (ctrl_q.resultsrc == RESULT_MEM);
  assign mem_op     = ctrl_q.memwrite | is_load;
  assign is_half    = (f3_q[1:0] == 2'b01);
  assign is_word    = (f3_q[1:0] == 2'b10);
  assign misaligned = mem_op & ((is_half & alu_q[0]) | (is_word & (alu_q[1:0] != 2'b00)));
  assign mis_trap   = misaligned & MISALIGN_TRAP;
  assign trap_in    = trap_q.valid;
  // Without trapping, a misaligned access is issued as if word-aligned.
  assign off        = misaligned ? 2'b00 : alu_q[1:0];

  assign req = mem_op & ~mis_trap & ~trap_in & ~kill_w &
               ((state_q == ST_RUN) || (state_q == ST_WAIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (req && !dmem_gnt) begin
          state_d = ST_WAIT;
          stall   = 1'b1;
        end
      end
      ST_WAIT: begin
        if (!req || dmem_gnt) state_d = ST_RUN;
        else                  stall   = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign stall_m = stall;

  always_comb begin
    be_raw    = 4'b1111;
    wdata_raw = sd_q;
    case (f3_q[1:0])
      2'b00: begin
        be_raw    = 4'b0001 << off;
        wdata_raw = {4{sd_q[7:0]}};
      end
      2'b01: begin
        be_raw    = 4'b0011 << off;
        wdata_raw = {2{sd_q[15:0]}};
      end
      default: begin
        be_raw    = 4'b1111;
        wdata_raw = sd_q;
      end
    endcase
  end

  assign dmem_req   = req;
  assign dmem_we    = req & ctrl_q.memwrite;
  assign dmem_addr  = req ? {alu_q[31:2], 2'b00} : 32'd0;
  assign dmem_be    = req ? be_raw : 4'd0;
  assign dmem_wdata = req ? wdata_raw : 32'd0;

  always_comb begin
    control_signal_m = ctrl_q;
    if (mis_trap) control_signal_m.regwrite = 1'b0;
    if (stall || kill_w) control_signal_m = '0;
  end

  always_comb begin
    trap_req_m = '0;
    if (trap_in) begin
      trap_req_m = trap_q;
    end else if (mis_trap) begin
      trap_req_m.valid = 1'b1;
      trap_req_m.cause = ctrl_q.memwrite ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
      trap_req_m.pc    = pc_q;
      trap_req_m.tval  = alu_q;
    end
    if (stall || kill_w) trap_req_m = '0;
  end

  assign rd_m     = rd_q;
  assign result_m = alu_q;

  // While stalled, report a load so the hazard unit holds dependents.
  always_comb begin
    haz.rd_m       = rd_q;
    haz.regwrite_m = ctrl_q.regwrite & ~mis_trap;
    haz.load_m     = is_load | stall;
    haz.stall_m    = stall;
  end

  assign hazard_bus.req = haz;

  assign rd_gnt = req & ~ctrl_q.memwrite & dmem_gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lf_valid_q <= 1'b0;
      lf_f3_q    <= '0;
      lf_off_q   <= '0;
    end else if (rd_gnt) begin
      lf_valid_q <= 1'b1;
      lf_f3_q    <= f3_q;
      lf_off_q   <= off;
    end else begin
      lf_valid_q <= 1'b0;
    end
  end

  always_comb begin
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    case (lf_off_q)
      2'd0:    lane_b = dmem_rdata[7:0];
      2'd1:    lane_b = dmem_rdata[15:8];
      2'd2:    lane_b = dmem_rdata[23:16];
      default: lane_b = dmem_rdata[31:24];
    endcase
    lane_h = lf_off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (lf_f3_q)
      3'b000:  memresult_m = {{24{lane_b[7]}}, lane_b};
      3'b100:  memresult_m = {24'd0, lane_b};
      3'b001:  memresult_m = {{16{lane_h[15]}}, lane_h};
      3'b101:  memresult_m = {16'd0, lane_h};
      default: memresult_m = dmem_rdata;
    endcase
    if (!(lf_valid_q && dmem_rvalid)) memresult_m = 32'd0;
  end

endmodule

// File: tb/tb_stage_mem.sv
// Scoreboard bench for stage_mem: bench-side memory model with programmable
// grant latency, expected loads/stores queued at issue and retired at the handshake.
module tb_stage_mem;
  import stage_mem_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  control_signal_t control_signal_e;
  logic [2:0]      funct3_e;
  logic [4:0]      rd_e;
  logic [31:0]     alu_result_e, store_data_e, pc_e;
  trap_req_t       trap_req_e;
  logic            kill_w;
  control_signal_t control_signal_m;
  logic [4:0]      rd_m;
  logic [31:0]     result_m, memresult_m;
  trap_req_t       trap_req_m;
  logic            dmem_req, dmem_we, dmem_gnt, dmem_rvalid, stall_m;
  logic [31:0]     dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]      dmem_be;

  hazard_interface hz ();

  stage_mem dut (
    .clk(clk), .rst(rst),
    .control_signal_e(control_signal_e), .funct3_e(funct3_e), .rd_e(rd_e),
    .alu_result_e(alu_result_e), .store_data_e(store_data_e), .pc_e(pc_e),
    .trap_req_e(trap_req_e), .kill_w(kill_w),
    .control_signal_m(control_signal_m), .rd_m(rd_m), .result_m(result_m),
    .memresult_m(memresult_m), .trap_req_m(trap_req_m),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .stall_m(stall_m), .hazard_bus(hz)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] rdata; logic [31:0] exp; } ld_t;
  typedef struct { logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } st_t;

  ld_t ld_q[$];
  st_t st_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  wait_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rw, input logic mw, input resultsrc_t rs,
                       input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] sd, input logic [31:0] pc);
    control_signal_e = '{regwrite: rw, memwrite: mw, resultsrc: rs};
    funct3_e     = f3;
    rd_e         = rd;
    alu_result_e = a;
    store_data_e = sd;
    pc_e         = pc;
    trap_req_e   = '0;
  endtask

  task automatic bubble();
    control_signal_e = '0;
    funct3_e = '0; rd_e = '0; alu_result_e = '0;
    store_data_e = '0; pc_e = '0; trap_req_e = '0;
  endtask

  // Retire handshakes seen before the edge, then model the memory after it.
  task automatic cycle();
    logic rd_acc, wr_acc;
    ld_t  l;
    st_t  s;
    rd_acc = dmem_req && dmem_gnt && !dmem_we;
    wr_acc = dmem_req && dmem_gnt && dmem_we;
    if (dmem_req && !dmem_gnt && wait_cnt > 0) wait_cnt--;
    if (wr_acc) begin
      if (st_q.size() == 0) chk("unexpected_write_q", st_q.size(), 1);
      else begin
        s = st_q.pop_front();
        chk("wr_addr",  dmem_addr,  s.addr);
        chk("wr_be",    dmem_be,    s.be);
        chk("wr_wdata", dmem_wdata, s.wdata);
      end
    end
    @(posedge clk);
    #1;
    dmem_gnt = (wait_cnt == 0);
    if (rd_acc && ld_q.size() > 0) begin
      l = ld_q.pop_front();
      dmem_rvalid = 1'b1;
      dmem_rdata  = l.rdata;
      #1;
      chk("memresult", memresult_m, l.exp);
    end else begin
      if (rd_acc) chk("unexpected_read_q", ld_q.size(), 1);
      dmem_rvalid = 1'b0;
      dmem_rdata  = '0;
      #1;
      chk("memresult_idle", memresult_m, 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; kill_w = 1'b0; dmem_gnt = 1'b1; dmem_rvalid = 1'b0; dmem_rdata = '0;
    bubble();
    #1;
    chk("rst_req",   dmem_req, 0);
    chk("rst_stall", stall_m, 0);
    chk("rst_ctrl",  control_signal_m, 0);
    chk("rst_trap",  trap_req_m, 0);
    chk("rst_memres", memresult_m, 0);
    @(negedge clk); rst = 1'b0;

    // LW 0x100, immediate grant
    drive(1, 0, RESULT_MEM, 3'b010, 5'd5, 32'h100, 0, 32'h10);
    ld_q.push_back('{rdata: 32'hDEADBEEF, exp: 32'hDEADBEEF});
    cycle(); bubble();
    chk("lw_req",   dmem_req, 1);
    chk("lw_we",    dmem_we, 0);
    chk("lw_addr",  dmem_addr, 32'h100);
    chk("lw_be",    dmem_be, 4'b1111);
    chk("lw_stall", stall_m, 0);
    chk("lw_rs",    control_signal_m.resultsrc, RESULT_MEM);
    chk("lw_rd",    rd_m, 5);
    chk("lw_haz_rd", hz.req.rd_m, 5);

    // LB / LBU at 0x103, LH at 0x102, back to back
    drive(1, 0, RESULT_MEM, 3'b000, 5'd6, 32'h103, 0, 32'h14);
    cycle();
    ld_q.push_back('{rdata: 32'h80FF7F01, exp: 32'hFFFFFF80});
    chk("lb_be", dmem_be, 4'b1000);
    drive(1, 0, RESULT_MEM, 3'b100, 5'd7, 32'h103, 0, 32'h18);
    cycle();
    ld_q.push_back('{rdata: 32'h80FF7F01, exp: 32'h00000080});
    chk("lbu_addr", dmem_addr, 32'h100);
    drive(1, 0, RESULT_MEM, 3'b001, 5'd8, 32'h102, 0, 32'h1C);
    cycle();
    ld_q.push_back('{rdata: 32'h80FF7F01, exp: 32'hFFFF80FF});
    chk("lh_be", dmem_be, 4'b1100);

    // SB 0x201 with grant withheld for 3 cycles
    wait_cnt = 3;
    drive(0, 1, RESULT_ALU, 3'b000, 5'd0, 32'h201, 32'h12345678, 32'h20);
    st_q.push_back('{addr: 32'h200, be: 4'b0010, wdata: 32'h78787878});
    cycle(); bubble();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("sb_stall",  stall_m, 1);
      chk("sb_be",     dmem_be, 4'b0010);
      chk("sb_wdata",  dmem_wdata, 32'h78787878);
      chk("sb_addr",   dmem_addr, 32'h200);
      chk("sb_bubble", control_signal_m, 0);
      chk("sb_haz_load", hz.req.load_m, 1);
      cycle();
    end
    #1;
    chk("sb_gnt_stall", stall_m, 0);
    chk("sb_gnt_we",    dmem_we, 1);
    cycle();
    chk("sb_after_req", dmem_req, 0);

    // Misaligned SW and LH
    drive(0, 1, RESULT_ALU, 3'b010, 5'd0, 32'h102, 32'hAAAA5555, 32'h40);
    cycle();
    chk("sw_mis_req",   dmem_req, 0);
    chk("sw_mis_valid", trap_req_m.valid, 1);
    chk("sw_mis_cause", trap_req_m.cause, 6);
    chk("sw_mis_pc",    trap_req_m.pc, 32'h40);
    chk("sw_mis_tval",  trap_req_m.tval, 32'h102);
    drive(1, 0, RESULT_MEM, 3'b001, 5'd7, 32'h101, 0, 32'h44);
    cycle();
    chk("lh_mis_req",   dmem_req, 0);
    chk("lh_mis_cause", trap_req_m.cause, 4);
    chk("lh_mis_tval",  trap_req_m.tval, 32'h101);
    chk("lh_mis_rw",    control_signal_m.regwrite, 0);
    chk("lh_mis_haz_rw", hz.req.regwrite_m, 0);

    // Upstream trap passes through and blocks the access
    drive(1, 0, RESULT_MEM, 3'b010, 5'd3, 32'h108, 0, 32'h50);
    trap_req_e = '{valid: 1'b1, cause: 4'd2, pc: 32'h50, tval: 32'h1234};
    cycle();
    chk("trapin_req",  dmem_req, 0);
    chk("trapin_pass", trap_req_m, {1'b1, 4'd2, 32'h50, 32'h1234});

    // Plain ALU op
    drive(1, 0, RESULT_ALU, 3'b000, 5'd9, 32'h55, 0, 32'h60);
    cycle(); bubble();
    chk("alu_req",    dmem_req, 0);
    chk("alu_result", result_m, 32'h55);
    chk("alu_rw",     control_signal_m.regwrite, 1);
    chk("alu_rd",     rd_m, 9);
    chk("alu_trap",   trap_req_m, 0);

    // Store stuck in WAIT, killed from WB
    wait_cnt = 5;
    drive(0, 1, RESULT_ALU, 3'b010, 5'd0, 32'h300, 32'h0BADF00D, 32'h70);
    cycle(); bubble();
    #1;
    chk("kill_pre_stall", stall_m, 1);
    kill_w = 1'b1;
    #1;
    chk("kill_req",   dmem_req, 0);
    chk("kill_stall", stall_m, 0);
    chk("kill_ctrl",  control_signal_m, 0);
    cycle();
    kill_w = 1'b0; wait_cnt = 0;
    #1;
    chk("kill_after_req",  dmem_req, 0);
    chk("kill_after_ctrl", control_signal_m, 0);
    cycle();
    chk("kill_after2_req", dmem_req, 0);

    // Asynchronous reset while waiting on a load
    wait_cnt = 4;
    drive(1, 0, RESULT_MEM, 3'b010, 5'd4, 32'h400, 0, 32'h80);
    cycle(); bubble();
    #1;
    chk("rstw_pre_stall", stall_m, 1);
    #1 rst = 1'b1;
    #1;
    chk("rstw_req",    dmem_req, 0);
    chk("rstw_stall",  stall_m, 0);
    chk("rstw_ctrl",   control_signal_m, 0);
    chk("rstw_result", result_m, 0);
    chk("rstw_addr",   dmem_addr, 0);
    rst = 1'b0; wait_cnt = 0;
    cycle();
    drive(1, 0, RESULT_MEM, 3'b010, 5'd11, 32'h104, 0, 32'h84);
    ld_q.push_back('{rdata: 32'hCAFEF00D, exp: 32'hCAFEF00D});
    cycle(); bubble();
    chk("post_rst_req",   dmem_req, 1);
    chk("post_rst_stall", stall_m, 0);
    chk("post_rst_addr",  dmem_addr, 32'h104);
    cycle();
    cycle();

    chk("ld_q_empty", ld_q.size(), 0);
    chk("st_q_empty", st_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stage_mem.md
Name: stage_mem

Overview:
- Memory-access pipeline stage between execute and writeback.
- Registers the EX-stage instruction and drives the data-memory request/grant interface.
- Produces the load-data lane select and sign extension, and detects misaligned accesses.
- Presents control_signal_m / rd_m / result_m / memresult_m / trap_req_m to writeback with the fixed timing that writeback consumes.

Parameters:
- MISALIGN_TRAP, 1, 1 = misaligned load/store raises a trap and suppresses the access; 0 = the access is issued with addr[1:0] forced to 0.
- CAUSE_LD_MISALIGN, 4, trap cause code for a misaligned load.
- CAUSE_ST_MISALIGN, 6, trap cause code for a misaligned store.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high; clears every register
- control_signal_e  in  control_signal_t  EX control; uses .regwrite, .memwrite, .resultsrc
- funct3_e  in  3  load/store width and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- rd_e  in  5  destination register
- alu_result_e  in  32  address or ALU result
- store_data_e  in  32  forwarded rs2 value
- pc_e  in  32  instruction PC, used for trap reporting
- trap_req_e  in  trap_req_t  trap raised upstream
- kill_w  in  1  trap committing in WB; kills the M instruction
- control_signal_m  out  control_signal_t  to WB; '0 while stalled or killed
- rd_m  out  5  to WB
- result_m  out  32  registered alu_result
- memresult_m  out  32  formatted load data, valid in the WB cycle
- trap_req_m  out  trap_req_t  to WB; fields .valid, .cause, .pc, .tval
- dmem_req  out  1  access request
- dmem_we  out  1  write
- dmem_addr  out  32  word address (addr[1:0] = 0)
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-shifted store data
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  read data valid; exactly 1 cycle after a read gnt
- dmem_rdata  in  32  read data
- stall_m  out  1  freeze the EX/M register and everything upstream
- hazard_bus  hazard_interface.requester  drives req.rd_m, req.regwrite_m, req.load_m, req.stall_m

Behaviour:
- Reset:
  - M register, FSM (RUN), load-format register and all outputs = 0.
  - dmem_req = 0, stall_m = 0.
- M register update, per clock:
  - kill_w = 1 → load a bubble ('0).
  - Otherwise stall_m = 1 → hold.
  - Otherwise capture the *_e inputs.
- Access detection:
  - mem_op = memwrite | (resultsrc == RESULT_MEM).
  - Misaligned: H with addr[0] = 1, or W with addr[1:0] ≠ 0.
- Misaligned access with MISALIGN_TRAP = 1:
  - No dmem_req.
  - trap_req_m = {valid 1, cause CAUSE_LD_MISALIGN or CAUSE_ST_MISALIGN, pc, tval = addr}.
  - control_signal_m.regwrite forced to 0.
- Incoming trap: trap_req_e.valid passes through unchanged and suppresses the memory access.
- Request:
  - dmem_req = mem_op & ~misaligned-trap & ~trap_in & ~kill_w & (state == RUN or WAIT).
  - dmem_be: B = 0001 << addr[1:0]; H = 0011 << addr[1:0]; W = 1111.
  - dmem_wdata: byte replicated ×4, half ×2, word as-is.
- FSM:
  - RUN: dmem_req & ~dmem_gnt → WAIT, stall_m = 1. dmem_req & dmem_gnt → stay RUN, no stall.
  - WAIT: dmem_req held with stable address/data/be, stall_m = 1. dmem_gnt → RUN. kill_w → RUN, request dropped, no stall.
- Output gating while stall_m = 1:
  - control_signal_m = '0 and trap_req_m = '0, so WB sees a bubble each stalled cycle.
  - hazard_bus still reports the real rd/regwrite with load_m = 1 so dependent instructions stall.
- Load format:
  - On a read gnt, register {valid, funct3, addr[1:0]}; otherwise clear valid.
  - Next cycle: memresult_m = lane-extracted dmem_rdata, sign- or zero-extended per funct3; memresult_m = 0 when valid = 0.
  - dmem_rvalid low while valid = 1 is a protocol error; the bench asserts on it.
- Non-memory instructions: single cycle, result_m = alu_result.
- Simultaneous kill_w and dmem_gnt: the grant is ignored for writes (the memory must not commit a store whose req was low), so a kill takes precedence because req is already deasserted combinationally.
- Reset mid-WAIT: return to RUN with no request.

Test Plan:
- LW at 0x100, gnt same cycle, rdata 0xDEADBEEF → no stall; WB cycle shows memresult_m = 0xDEADBEEF, control_signal_m.resultsrc = RESULT_MEM, rd_m correct.
- LB at 0x103, rdata 0x80FF7F01 → memresult_m = 0xFFFFFF80; LBU at the same address → 0x00000080; LH at 0x102 → 0xFFFF80FF.
- SB at 0x201, store_data 0x12345678, gnt withheld 3 cycles → stall_m high 3 cycles, dmem_be = 0010 and wdata = 0x78787878 stable throughout, WB sees 3 bubbles, then a single write.
- SW at 0x102 → no dmem_req, trap_req_m = {1, 6, pc, 0x102}; LH at 0x101 → cause 4, tval 0x101.
- Store in WAIT with kill_w pulsed → dmem_req drops the same cycle, FSM returns to RUN, M register holds a bubble, no write is observed.
- rst asserted asynchronously mid-WAIT → all outputs 0 immediately, stall_m = 0; the next load after rst deasserts completes normally.
